// File: rtl/mod_clk_monitor_pkg.sv
// Shared types and constants for the modulation-clock monitor.
package mod_clk_monitor_pkg;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } state_t;

    // All-ones marker published when an input never rose within a MOD period.
    function automatic logic [63:0] f_no_edge(input int unsigned cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain plus history flop; level/rise/fall valid SYNC_STAGES cycles after the pin.
// No flow control: one sample per cycle, edges are single-cycle pulses.
module sync_edge_det
    import mod_clk_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/mod_clk_monitor.sv
// Times looped-back MOD/MODN/MODL: period, high time, phases, overlap and loss of clock.
// Results registered one cycle after the synced MOD rise; no backpressure, MEAS_VALID is a pulse.
module mod_clk_monitor
    import mod_clk_monitor_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic             i_user_clock,
    input  logic             i_reset_n,
    input  logic             i_mod_in,
    input  logic             i_modn_in,
    input  logic             i_modl_in,
    input  logic             i_ovl_clr,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_time,
    output logic [CNT_W-1:0] o_phase_n,
    output logic [CNT_W-1:0] o_phase_l,
    output logic             o_meas_valid,
    output logic             o_overlap_err,
    output logic             o_clk_lost
);

    localparam logic [63:0]      NO_EDGE_W = f_no_edge(CNT_W);
    localparam logic [CNT_W-1:0] NO_EDGE   = NO_EDGE_W[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_RUN    = CNT_W'(TIMEOUT);
    // Idle count starts at 0 on the last reset cycle, so one less lands on the same cycle count.
    localparam logic [CNT_W-1:0] TO_IDLE   = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
        return (v == NO_EDGE) ? v : v + ONE;
    endfunction

    logic w_mod_level, w_mod_rise, w_mod_fall;
    logic w_modn_level, w_modn_rise, w_modn_fall;
    logic w_modl_level, w_modl_rise, w_modl_fall;
    logic w_unused_ok;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mod (
        .i_clk   (i_user_clock),
        .i_rst_n (i_reset_n),
        .i_async (i_mod_in),
        .o_level (w_mod_level),
        .o_rise  (w_mod_rise),
        .o_fall  (w_mod_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_modn (
        .i_clk   (i_user_clock),
        .i_rst_n (i_reset_n),
        .i_async (i_modn_in),
        .o_level (w_modn_level),
        .o_rise  (w_modn_rise),
        .o_fall  (w_modn_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_modl (
        .i_clk   (i_user_clock),
        .i_rst_n (i_reset_n),
        .i_async (i_modl_in),
        .o_level (w_modl_level),
        .o_rise  (w_modl_rise),
        .o_fall  (w_modl_fall)
    );

    // High counter only advances on synced level, so the fall pulse is implied.
    assign w_unused_ok = ^{w_mod_fall, w_modn_fall, w_modl_fall, w_modl_level};

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_phn_cnt, r_phl_cnt;
    logic             r_n_seen, r_l_seen;
    logic [CNT_W-1:0] r_res_period, r_res_high, r_res_phn, r_res_phl;
    logic             r_meas_valid;
    logic             r_overlap;
    logic             w_publish;

    always_ff @(posedge i_user_clock) begin
        if (!i_reset_n) begin
            r_state <= ACQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACQ: begin
                if (w_mod_rise) begin
                    w_state_nxt = RUN;
                end else if (r_idle_cnt == TO_IDLE) begin
                    w_state_nxt = LOST;
                end
            end
            RUN: begin
                if (!w_mod_rise && (r_per_cnt == TO_RUN)) begin
                    w_state_nxt = LOST;
                end
            end
            LOST: begin
                if (w_mod_rise) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = ACQ;
        endcase
    end

    assign w_publish = (r_state == RUN) && w_mod_rise;

    always_ff @(posedge i_user_clock) begin
        if (!i_reset_n) begin
            r_idle_cnt <= '0;
            r_per_cnt  <= '0;
            r_high_cnt <= '0;
        end else begin
            if (r_state == ACQ) begin
                r_idle_cnt <= f_inc(r_idle_cnt);
            end
            if (w_mod_rise) begin
                r_per_cnt  <= ONE;
                r_high_cnt <= ONE;
            end else begin
                r_per_cnt <= f_inc(r_per_cnt);
                if (w_mod_level) begin
                    r_high_cnt <= f_inc(r_high_cnt);
                end
            end
        end
    end

    // Phase counters freeze on the first rise of their input; a rise coinciding
    // with the MOD rise counts as zero delay.
    always_ff @(posedge i_user_clock) begin
        if (!i_reset_n) begin
            r_phn_cnt <= '0;
            r_phl_cnt <= '0;
            r_n_seen  <= 1'b0;
            r_l_seen  <= 1'b0;
        end else if (w_mod_rise) begin
            r_phn_cnt <= w_modn_rise ? '0 : ONE;
            r_phl_cnt <= w_modl_rise ? '0 : ONE;
            r_n_seen  <= w_modn_rise;
            r_l_seen  <= w_modl_rise;
        end else begin
            if (!r_n_seen) begin
                if (w_modn_rise) begin
                    r_n_seen <= 1'b1;
                end else begin
                    r_phn_cnt <= f_inc(r_phn_cnt);
                end
            end
            if (!r_l_seen) begin
                if (w_modl_rise) begin
                    r_l_seen <= 1'b1;
                end else begin
                    r_phl_cnt <= f_inc(r_phl_cnt);
                end
            end
        end
    end

    always_ff @(posedge i_user_clock) begin
        if (!i_reset_n) begin
            r_res_period <= '0;
            r_res_high   <= '0;
            r_res_phn    <= '0;
            r_res_phl    <= '0;
            r_meas_valid <= 1'b0;
        end else begin
            r_meas_valid <= w_publish;
            if (w_publish) begin
                r_res_period <= r_per_cnt;
                r_res_high   <= r_high_cnt;
                r_res_phn    <= r_n_seen ? r_phn_cnt : NO_EDGE;
                r_res_phl    <= r_l_seen ? r_phl_cnt : NO_EDGE;
            end
        end
    end

    always_ff @(posedge i_user_clock) begin
        if (!i_reset_n) begin
            r_overlap <= 1'b0;
        end else if (w_mod_level && w_modn_level) begin
            r_overlap <= 1'b1;
        end else if (i_ovl_clr) begin
            r_overlap <= 1'b0;
        end
    end

    assign o_period      = r_res_period;
    assign o_high_time   = r_res_high;
    assign o_phase_n     = r_res_phn;
    assign o_phase_l     = r_res_phl;
    assign o_meas_valid  = r_meas_valid;
    assign o_overlap_err = r_overlap;
    assign o_clk_lost    = (r_state == LOST);

endmodule

// File: tb/tb_mod_clk_monitor.sv
module tb_mod_clk_monitor;

    localparam int CW  = 16;
    localparam int TO  = 4096;
    localparam int SS  = 2;
    localparam int CW2 = 8;
    localparam int TO2 = 255;
    localparam int NONE = 'hFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mod, modn, modl, clr;
    logic mod2, modn2, modl2, clr2;
    logic [CW-1:0]  period, high_time, phase_n, phase_l;
    logic           meas_valid, overlap_err, clk_lost;
    logic [CW2-1:0] period2, high_time2, phase_n2, phase_l2;
    logic           meas_valid2, overlap_err2, clk_lost2;

    mod_clk_monitor #(.CNT_W(CW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .i_user_clock (clk),
        .i_reset_n    (rst_n),
        .i_mod_in     (mod),
        .i_modn_in    (modn),
        .i_modl_in    (modl),
        .i_ovl_clr    (clr),
        .o_period     (period),
        .o_high_time  (high_time),
        .o_phase_n    (phase_n),
        .o_phase_l    (phase_l),
        .o_meas_valid (meas_valid),
        .o_overlap_err(overlap_err),
        .o_clk_lost   (clk_lost)
    );

    mod_clk_monitor #(.CNT_W(CW2), .SYNC_STAGES(SS), .TIMEOUT(TO2)) dut2 (
        .i_user_clock (clk),
        .i_reset_n    (rst_n),
        .i_mod_in     (mod2),
        .i_modn_in    (modn2),
        .i_modl_in    (modl2),
        .i_ovl_clr    (clr2),
        .o_period     (period2),
        .o_high_time  (high_time2),
        .o_phase_n    (phase_n2),
        .o_phase_l    (phase_l2),
        .o_meas_valid (meas_valid2),
        .o_overlap_err(overlap_err2),
        .o_clk_lost   (clk_lost2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Expected measurement of one whole MOD period, in cycles.
    typedef struct {
        int p;
        int h;
        int n;
        int l;
        bit first;
    } exp_t;

    exp_t q[$];
    exp_t prev;
    bit   have_prev;
    bit   first_pub;
    int   rise_edge;
    int   n_valid = 0;
    int   last_v  = -100000;
    int   lost_up = -100000, lost_dn = -100000;
    logic prev_lost = 1'b0;

    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            chk("expect_pending", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("period", period, e.p);
                chk("high_time", high_time, e.h);
                chk("phase_n", phase_n, e.n);
                chk("phase_l", phase_l, e.l);
                if (!e.first) chk("valid_gap", cyc - last_v, e.p);
            end
            last_v = cyc;
            n_valid++;
        end
        if (clk_lost === 1'b1 && prev_lost === 1'b0) lost_up = cyc;
        if (clk_lost === 1'b0 && prev_lost === 1'b1) lost_dn = cyc;
        prev_lost = clk_lost;
    end

    int   nv2 = 0;
    int   v2_cyc = -100000;
    int   lost2_up = -100000, lost2_dn = -100000;
    int   r2_edge;
    logic prev_lost2 = 1'b0;
    logic [CW2-1:0] p2_last, h2_last, pn2_last, pl2_last;

    always @(negedge clk) begin
        if (meas_valid2 === 1'b1) begin
            nv2++;
            v2_cyc   = cyc;
            p2_last  = period2;
            h2_last  = high_time2;
            pn2_last = phase_n2;
            pl2_last = phase_l2;
        end
        if (clk_lost2 === 1'b1 && prev_lost2 === 1'b0) lost2_up = cyc;
        if (clk_lost2 === 1'b0 && prev_lost2 === 1'b1) lost2_dn = cyc;
        prev_lost2 = clk_lost2;
    end

    // One MOD period of p cycles: MOD high [0,h), MODN high [dn,dn+wn), MODL high [dl,dl+wl).
    task automatic drive_period(input int p, input int h, input int dn, input int wn,
                                input int dl, input int wl, input bit hn, input bit hl,
                                input int clr_at, input int rst_at);
        if (have_prev) begin
            prev.first = first_pub;
            q.push_back(prev);
            first_pub = 1'b0;
        end
        prev.p = p;
        prev.h = h;
        prev.n = hn ? dn : NONE;
        prev.l = hl ? dl : NONE;
        have_prev = 1'b1;
        for (int c = 0; c < p; c++) begin
            @(negedge clk);
            mod   = (c < h);
            modn  = hn && (c >= dn) && (c < dn + wn);
            modl  = hl && (c >= dl) && (c < dl + wl);
            clr   = (c == clr_at);
            rst_n = !(c == rst_at);
            if (c == 0) rise_edge = cyc + 1;
        end
        if (rst_at >= 0) begin
            have_prev = 1'b0;
            first_pub = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        have_prev = 1'b0;
        first_pub = 1'b1;
        repeat (n) begin
            @(negedge clk);
            mod = 1'b0; modn = 1'b0; modl = 1'b0; clr = 1'b0;
        end
    endtask

    task automatic drive2(input int p, input int h);
        for (int c = 0; c < p; c++) begin
            @(negedge clk);
            mod2 = (c < h);
            if (c == 0) r2_edge = cyc + 1;
        end
    endtask

    initial begin
        int nv0;
        rst_n = 1'b0; mod = 1'b0; modn = 1'b0; modl = 1'b0; clr = 1'b0;
        mod2 = 1'b0; modn2 = 1'b0; modl2 = 1'b0; clr2 = 1'b0;
        have_prev = 1'b0; first_pub = 1'b1;
        repeat (4) @(negedge clk);

        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_phase_n", phase_n, 0);
        chk("rst_phase_l", phase_l, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_overlap", overlap_err, 0);
        chk("rst_lost", clk_lost, 0);
        chk("rst_lost2", clk_lost2, 0);

        // Idle after reset release: loss of clock exactly TIMEOUT cycles later.
        rst_n = 1'b1;
        repeat (TO - 1) @(posedge clk);
        #1 chk("acq_lost_early", clk_lost, 0);
        chk("acq_lost2", clk_lost2, 1);
        @(posedge clk);
        #1 chk("acq_lost_at_to", clk_lost, 1);

        // 1 MHz, 50% duty, MODN +500 ns, MODL +250 ns.
        drive_period(100, 50, 50, 40, 25, 20, 1, 1, -1, -1);
        chk("restart_drop_lat", lost_dn - rise_edge, SS);
        chk("first_rise_no_valid", n_valid, 0);
        for (int k = 0; k < 4; k++) drive_period(100, 50, 50, 40, 25, 20, 1, 1, -1, -1);
        chk("valid_count_1mhz", n_valid, 4);

        // Random non-overlapping waveforms; first one has MODL rising with MOD.
        for (int k = 0; k < 12; k++) begin
            int p, h, dn, wn, dl, wl;
            bit hn, hl;
            p  = $urandom_range(150, 6);
            h  = $urandom_range(p - 2, 1);
            dn = $urandom_range(p - 2, h);
            wn = $urandom_range(p - 1 - dn, 1);
            dl = (k == 0) ? 0 : $urandom_range(p - 2, 0);
            wl = $urandom_range(p - 1 - dl, 1);
            hn = ($urandom_range(3, 0) != 0);
            hl = (k == 0) || ($urandom_range(3, 0) != 0);
            drive_period(p, h, dn, wn, dl, wl, hn, hl, -1, -1);
        end
        chk("ovl_clean", overlap_err, 0);
        idle(TO + 40);
        chk("lost_after_last", lost_up - last_v, TO);
        chk("queue_drained", q.size(), 0);

        // Overlap: 3 cycles of MOD&MODN, with MODN rising alongside MOD.
        drive_period(30, 5, 0, 3, 0, 0, 1, 0, -1, -1);
        chk("ovl_set", overlap_err, 1);
        drive_period(30, 10, 15, 5, 20, 5, 1, 1, 5, -1);
        chk("ovl_cleared", overlap_err, 0);
        drive_period(30, 5, 0, 1, 0, 0, 1, 0, 2, -1);
        chk("ovl_set_beats_clr", overlap_err, 1);

        // Reset during a period: no partial result, re-acquire on next rise.
        for (int k = 0; k < 3; k++) drive_period(30, 10, 15, 5, 20, 5, 1, 1, -1, -1);
        drive_period(40, 10, 20, 5, 0, 5, 1, 1, -1, 37);
        chk("midrst_period", period, 0);
        chk("midrst_high", high_time, 0);
        chk("midrst_phase_n", phase_n, 0);
        chk("midrst_phase_l", phase_l, 0);
        chk("midrst_overlap", overlap_err, 0);
        chk("midrst_lost", clk_lost, 0);
        nv0 = n_valid;
        drive_period(50, 20, 30, 10, 5, 5, 1, 0, -1, -1);
        chk("midrst_first_rise", n_valid - nv0, 0);
        drive_period(60, 20, 30, 10, 5, 5, 0, 1, -1, -1);
        drive_period(50, 20, 30, 10, 5, 5, 1, 1, -1, -1);
        chk("midrst_valids", n_valid - nv0, 2);
        idle(300);
        chk("queue_drained2", q.size(), 0);

        // Narrow instance: 200 kHz MOD times out after every rise.
        chk("w8_lost_pre", clk_lost2, 1);
        for (int k = 0; k < 3; k++) begin
            drive2(500, 250);
            chk("w8_drop_lat", lost2_dn - r2_edge, SS);
            chk("w8_lost_after", lost2_up - lost2_dn, TO2);
        end
        chk("w8_no_valid", nv2, 0);
        for (int k = 0; k < 3; k++) drive2(255, 100);
        repeat (400) @(negedge clk);
        chk("w8_valids", nv2, 2);
        chk("w8_period", p2_last, 255);
        chk("w8_high", h2_last, 100);
        chk("w8_phase_n", pn2_last, 8'hFF);
        chk("w8_phase_l", pl2_last, 8'hFF);
        chk("w8_lost_timing", lost2_up - v2_cyc, TO2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
